// File: rtl/ex_mem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_stage
// Brief    : EX->MEM pipeline stage with valid/ready handshake, synchronous
//            flush, optional two-entry skid buffer and a saturating stall
//            counter. Scalar and vector-lane payloads travel as one packed
//            word; side-effect controls are gated by the head valid bit.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_skid_stage #(
    parameter int XLEN   = 32,
    parameter int LANES  = 3,
    parameter int LANE_W = 16,
    parameter int RA_W   = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mem_to_reg,
    input  logic                    in_mem_write,
    input  logic                    in_reg_write,
    input  logic                    in_vreg_write,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_alu,
    input  logic [XLEN-1:0]         in_rs2,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [RA_W-1:0]         in_rd,
    input  logic [RA_W-1:0]         in_vd,
    input  logic [LANES*LANE_W-1:0] in_valu,
    input  logic [LANES*LANE_W-1:0] in_vrs2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_mem_to_reg,
    output logic                    out_mem_write,
    output logic                    out_reg_write,
    output logic                    out_vreg_write,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_alu,
    output logic [XLEN-1:0]         out_rs2,
    output logic [XLEN-1:0]         out_imm,
    output logic [RA_W-1:0]         out_rd,
    output logic [RA_W-1:0]         out_vd,
    output logic [LANES*LANE_W-1:0] out_valu,
    output logic [LANES*LANE_W-1:0] out_vrs2,
    output logic [1:0]              occ,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int               c_VEC_W   = LANES * LANE_W;
    localparam int               c_PL_W    = 5 + 4 * XLEN + 2 * RA_W + 2 * c_VEC_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [c_PL_W-1:0] w_in_pl;
    logic [c_PL_W-1:0] r_m_pl;
    logic              r_m_valid;
    logic              w_s_valid;
    logic              w_accept;
    logic              w_drain;
    logic              w_m_mem_write;
    logic              w_m_reg_write;
    logic              w_m_vreg_write;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Whole entry moves as one word so both storage slots stay identical.
    assign w_in_pl = {in_mem_to_reg, in_mem_write, in_reg_write, in_vreg_write,
                      in_pc, in_alu, in_rs2, in_imm, in_rd, in_vd,
                      in_valu, in_vrs2};

    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_m_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_s_valid;
            logic [c_PL_W-1:0] r_s_pl;

            // in_ready comes straight off the skid valid flop, so out_ready
            // never reaches in_ready combinationally.
            assign in_ready  = !r_s_valid;
            assign w_s_valid = r_s_valid;

            // Two-slot FIFO: head refills from skid first, overflow parks in skid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_m_valid <= 1'b0;
                    r_m_pl    <= '0;
                    r_s_valid <= 1'b0;
                    r_s_pl    <= '0;
                end else if (flush) begin
                    r_m_valid <= 1'b0;
                    r_s_valid <= 1'b0;
                end else if (!r_m_valid || w_drain) begin
                    if (r_s_valid) begin
                        r_m_pl    <= r_s_pl;
                        r_m_valid <= 1'b1;
                        r_s_valid <= w_accept;
                        if (w_accept) begin
                            r_s_pl <= w_in_pl;
                        end
                    end else begin
                        r_m_valid <= w_accept;
                        if (w_accept) begin
                            r_m_pl <= w_in_pl;
                        end
                    end
                end else if (w_accept) begin
                    r_s_pl    <= w_in_pl;
                    r_s_valid <= 1'b1;
                end
            end
        end else begin : g_direct
            // Single slot: free to take a new entry whenever the head leaves.
            assign in_ready  = !r_m_valid || out_ready;
            assign w_s_valid = 1'b0;

            // Head register loads on accept, empties on an unreplaced drain.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_m_valid <= 1'b0;
                    r_m_pl    <= '0;
                end else if (flush) begin
                    r_m_valid <= 1'b0;
                end else if (w_accept) begin
                    r_m_valid <= 1'b1;
                    r_m_pl    <= w_in_pl;
                end else if (w_drain) begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign {out_mem_to_reg, w_m_mem_write, w_m_reg_write, w_m_vreg_write,
            out_pc, out_alu, out_rs2, out_imm, out_rd, out_vd,
            out_valu, out_vrs2} = r_m_pl;

    // A bubble must never trigger a store or a register write in MEM/WB.
    assign out_mem_write  = w_m_mem_write  & r_m_valid;
    assign out_reg_write  = w_m_reg_write  & r_m_valid;
    assign out_vreg_write = w_m_vreg_write & r_m_valid;

    assign out_valid = r_m_valid;
    assign occ       = {1'b0, r_m_valid} + {1'b0, w_s_valid};
    assign stall_cnt = r_stall_cnt;

    // Count cycles MEM refuses a valid head; survives flush, sticks at max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_skid_stage
// Brief    : Bench for ex_mem_skid_stage. A skid build (A) and a direct build
//            (B) share stimulus; a queue model per build predicts outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid_stage;

    typedef struct packed {
        logic [1:0]   m2r;
        logic         mw;
        logic         rw;
        logic         vw;
        logic [31:0]  pc;
        logic [31:0]  alu;
        logic [31:0]  rs2;
        logic [31:0]  imm;
        logic [4:0]   rd;
        logic [4:0]   vd;
        logic [127:0] valu;
        logic [127:0] vrs2;
    } pl_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        logic        ev;
        logic [31:0] epc;
        logic [1:0]  eocc;
        logic        eir;
        logic [3:0]  est;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic iv   = 1'b0;
    logic ordy = 1'b0;
    logic fl   = 1'b0;
    pl_t  cur_in = '0;

    logic       a_ir, a_ov, b_ir, b_ov;
    logic [1:0] a_occ, b_occ;
    logic [3:0] a_st, b_st;
    pl_t        a_obs, b_obs;

    int errors = 0;
    int checks = 0;
    logic seen_200 = 1'b0;

    pl_t        qa[$];
    pl_t        qb[$];
    pl_t        last_a = '0;
    pl_t        last_b = '0;
    logic [3:0] st_a = '0;
    logic [3:0] st_b = '0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    ex_mem_skid_stage #(.XLEN(32), .LANES(4), .LANE_W(32), .RA_W(5), .SKID(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .flush(fl), .in_valid(iv), .in_ready(a_ir),
        .in_mem_to_reg(cur_in.m2r), .in_mem_write(cur_in.mw), .in_reg_write(cur_in.rw),
        .in_vreg_write(cur_in.vw), .in_pc(cur_in.pc), .in_alu(cur_in.alu), .in_rs2(cur_in.rs2),
        .in_imm(cur_in.imm), .in_rd(cur_in.rd), .in_vd(cur_in.vd), .in_valu(cur_in.valu),
        .in_vrs2(cur_in.vrs2), .out_valid(a_ov), .out_ready(ordy),
        .out_mem_to_reg(a_obs.m2r), .out_mem_write(a_obs.mw), .out_reg_write(a_obs.rw),
        .out_vreg_write(a_obs.vw), .out_pc(a_obs.pc), .out_alu(a_obs.alu), .out_rs2(a_obs.rs2),
        .out_imm(a_obs.imm), .out_rd(a_obs.rd), .out_vd(a_obs.vd), .out_valu(a_obs.valu),
        .out_vrs2(a_obs.vrs2), .occ(a_occ), .stall_cnt(a_st)
    );

    ex_mem_skid_stage #(.XLEN(32), .LANES(4), .LANE_W(32), .RA_W(5), .SKID(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .flush(fl), .in_valid(iv), .in_ready(b_ir),
        .in_mem_to_reg(cur_in.m2r), .in_mem_write(cur_in.mw), .in_reg_write(cur_in.rw),
        .in_vreg_write(cur_in.vw), .in_pc(cur_in.pc), .in_alu(cur_in.alu), .in_rs2(cur_in.rs2),
        .in_imm(cur_in.imm), .in_rd(cur_in.rd), .in_vd(cur_in.vd), .in_valu(cur_in.valu),
        .in_vrs2(cur_in.vrs2), .out_valid(b_ov), .out_ready(ordy),
        .out_mem_to_reg(b_obs.m2r), .out_mem_write(b_obs.mw), .out_reg_write(b_obs.rw),
        .out_vreg_write(b_obs.vw), .out_pc(b_obs.pc), .out_alu(b_obs.alu), .out_rs2(b_obs.rs2),
        .out_imm(b_obs.imm), .out_rd(b_obs.rd), .out_vd(b_obs.vd), .out_valu(b_obs.valu),
        .out_vrs2(b_obs.vrs2), .occ(b_occ), .stall_cnt(b_st)
    );

    function automatic pl_t mk(input logic [31:0] pc);
        pl_t p;
        p.m2r  = pc[3:2];
        p.mw   = 1'b1;
        p.rw   = 1'b1;
        p.vw   = 1'b1;
        p.pc   = pc;
        p.alu  = pc ^ 32'hA5A5_0000;
        p.rs2  = ~pc;
        p.imm  = pc + 32'd1;
        p.rd   = pc[6:2];
        p.vd   = ~pc[6:2];
        p.valu = {pc, ~pc, pc ^ 32'h5A5A_5A5A, pc + 32'd3};
        p.vrs2 = {4{pc}};
        return p;
    endfunction

    function automatic pl_t gate(input pl_t p, input logic v);
        pl_t g = p;
        if (!v) begin
            g.mw = 1'b0;
            g.rw = 1'b0;
            g.vw = 1'b0;
        end
        return g;
    endfunction

    function automatic void row(input logic i_v, input logic o_r, input logic f,
                                input logic [31:0] pc, input logic ev, input logic [31:0] epc,
                                input logic [1:0] eocc, input logic eir, input logic [3:0] est);
        vec_t v;
        v.iv = i_v; v.ordy = o_r; v.fl = f; v.pc = pc;
        v.ev = ev; v.epc = epc; v.eocc = eocc; v.eir = eir; v.est = est;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each build is a FIFO of capacity 2 (A) or 1 (B).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete(); qb.delete();
            last_a = '0; last_b = '0;
            st_a = '0; st_b = '0;
        end else begin
            logic acc_a, acc_b, drn_a, drn_b;
            acc_a = iv && (qa.size() < 2);
            acc_b = iv && ((qb.size() == 0) || ordy);
            drn_a = (qa.size() != 0) && ordy;
            drn_b = (qb.size() != 0) && ordy;
            if ((qa.size() != 0) && !ordy && (st_a != 4'hF)) st_a = st_a + 4'd1;
            if ((qb.size() != 0) && !ordy && (st_b != 4'hF)) st_b = st_b + 4'd1;
            if (fl) begin
                qa.delete(); qb.delete();
            end else begin
                if (drn_a) void'(qa.pop_front());
                if (acc_a) qa.push_back(cur_in);
                if (drn_b) void'(qb.pop_front());
                if (acc_b) qb.push_back(cur_in);
            end
            if (qa.size() != 0) last_a = qa[0];
            if (qb.size() != 0) last_b = qb[0];
        end
    end

    // Compare both builds against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        logic va, vb;
        pl_t  ea, eb;
        va = (qa.size() != 0);
        vb = (qb.size() != 0);
        ea = gate(va ? qa[0] : last_a, va);
        eb = gate(vb ? qb[0] : last_b, vb);
        checks++;
        if (a_obs !== ea) begin
            errors++;
            $display("FAIL a_payload t=%0t got=%h expected=%h", $time, a_obs, ea);
        end
        checks++;
        if (b_obs !== eb) begin
            errors++;
            $display("FAIL b_payload t=%0t got=%h expected=%h", $time, b_obs, eb);
        end
        chk("a_status", {56'd0, a_ov, a_ir, a_occ, a_st},
            {56'd0, va, (qa.size() < 2), 2'(qa.size()), st_a});
        chk("b_status", {56'd0, b_ov, b_ir, b_occ, b_st},
            {56'd0, vb, ((qb.size() == 0) || ordy), 2'(qb.size()), st_b});
        if (a_obs.pc == 32'h200 || b_obs.pc == 32'h200) seen_200 = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming, back-pressure, flush rows for build A (expected after the edge).
        for (int i = 0; i < 8; i++) begin
            row(1, 1, 0, 32'h100 + 32'(4 * i), 1, 32'h100 + 32'(4 * i), 2'd1, 1, 4'd0);
        end
        row(0, 1, 0, 32'h0,   0, 32'h11C, 2'd0, 1, 4'd0);
        row(1, 1, 0, 32'h120, 1, 32'h120, 2'd1, 1, 4'd0);
        row(1, 0, 0, 32'h124, 1, 32'h120, 2'd2, 0, 4'd1);
        row(1, 0, 0, 32'h128, 1, 32'h120, 2'd2, 0, 4'd2);
        row(1, 0, 0, 32'h128, 1, 32'h120, 2'd2, 0, 4'd3);
        row(1, 0, 0, 32'h128, 1, 32'h120, 2'd2, 0, 4'd4);
        row(1, 1, 0, 32'h128, 1, 32'h124, 2'd1, 1, 4'd4);
        row(1, 1, 0, 32'h128, 1, 32'h128, 2'd1, 1, 4'd4);
        row(0, 1, 0, 32'h0,   0, 32'h128, 2'd0, 1, 4'd4);
        row(1, 0, 0, 32'h130, 1, 32'h130, 2'd1, 1, 4'd4);
        row(1, 0, 0, 32'h134, 1, 32'h130, 2'd2, 0, 4'd5);
        row(1, 1, 1, 32'h200, 0, 32'h130, 2'd0, 1, 4'd5);
        row(0, 1, 0, 32'h0,   0, 32'h130, 2'd0, 1, 4'd5);

        rst = 1'b1;
        #3;
        chk("rst_a_nonzero_payload", {63'd0, a_obs != '0}, 64'd0);
        chk("rst_a_status", {56'd0, a_ov, a_ir, a_occ, a_st}, {56'd0, 1'b0, 1'b1, 2'd0, 4'd0});
        repeat (2) tick();
        rst = 1'b0;

        foreach (tbl[i]) begin
            iv = tbl[i].iv; ordy = tbl[i].ordy; fl = tbl[i].fl;
            cur_in = mk(tbl[i].pc);
            tick();
            chk($sformatf("tbl%0d_valid", i), {63'd0, a_ov}, {63'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_pc", i), {32'd0, a_obs.pc}, {32'd0, tbl[i].epc});
            chk($sformatf("tbl%0d_occ", i), {62'd0, a_occ}, {62'd0, tbl[i].eocc});
            chk($sformatf("tbl%0d_in_ready", i), {63'd0, a_ir}, {63'd0, tbl[i].eir});
            chk($sformatf("tbl%0d_stall", i), {60'd0, a_st}, {60'd0, tbl[i].est});
            chk($sformatf("tbl%0d_wr_gate", i), {62'd0, a_obs.mw, a_obs.rw},
                {62'd0, tbl[i].ev, tbl[i].ev});
        end
        fl = 1'b0;

        // Async reset with build A full: outputs clear without a clock edge.
        iv = 1'b1; ordy = 1'b0; cur_in = mk(32'h140); tick();
        cur_in = mk(32'h144); tick();
        chk("pre_rst_occ", {62'd0, a_occ}, 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_a_payload", {63'd0, a_obs != '0}, 64'd0);
        chk("rst_async_b_payload", {63'd0, b_obs != '0}, 64'd0);
        chk("rst_async_a_status", {56'd0, a_ov, a_ir, a_occ, a_st}, {56'd0, 1'b0, 1'b1, 2'd0, 4'd0});
        chk("rst_async_b_status", {56'd0, b_ov, b_ir, b_occ, b_st}, {56'd0, 1'b0, 1'b1, 2'd0, 4'd0});
        rst = 1'b0;
        iv = 1'b1; ordy = 1'b1; cur_in = mk(32'h300);
        tick();
        chk("post_rst_a_accept", {31'd0, a_ov, a_obs.pc}, {31'd0, 1'b1, 32'h300});
        chk("post_rst_b_accept", {31'd0, b_ov, b_obs.pc}, {31'd0, 1'b1, 32'h300});

        // Wide vector lanes pass bit-exact.
        cur_in = mk(32'h400);
        cur_in.valu = 128'hDEADBEEF_01234567_89ABCDEF_FFFFFFFF;
        tick();
        chk("vec_a_hi", a_obs.valu[127:64], 64'hDEADBEEF_01234567);
        chk("vec_a_lo", a_obs.valu[63:0],   64'h89ABCDEF_FFFFFFFF);
        chk("vec_b_hi", b_obs.valu[127:64], 64'hDEADBEEF_01234567);
        chk("vec_b_lo", b_obs.valu[63:0],   64'h89ABCDEF_FFFFFFFF);
        iv = 1'b0; tick();

        // Direct build: in_ready follows out_ready within the cycle when full.
        iv = 1'b1; ordy = 1'b0; cur_in = mk(32'h500); tick();
        iv = 1'b0;
        #1 chk("comb_b_ready_lo0", {63'd0, b_ir}, 64'd0);
        ordy = 1'b1;
        #1 chk("comb_b_ready_hi", {63'd0, b_ir}, 64'd1);
        ordy = 1'b0;
        #1 chk("comb_b_ready_lo1", {63'd0, b_ir}, 64'd0);

        // 20 stalled cycles on a 4-bit counter.
        repeat (20) tick();
        chk("sat_a", {60'd0, a_st}, 64'd15);
        chk("sat_b", {60'd0, b_st}, 64'd15);
        ordy = 1'b1; tick();

        #2 rst = 1'b1;
        #2 rst = 1'b0;

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 19) == 0);
            cur_in.m2r  = 2'($urandom);
            cur_in.mw   = 1'($urandom);
            cur_in.rw   = 1'($urandom);
            cur_in.vw   = 1'($urandom);
            cur_in.pc   = $urandom | 32'h8000_0000;
            cur_in.alu  = $urandom;
            cur_in.rs2  = $urandom;
            cur_in.imm  = $urandom;
            cur_in.rd   = 5'($urandom);
            cur_in.vd   = 5'($urandom);
            cur_in.valu = {$urandom, $urandom, $urandom, $urandom};
            cur_in.vrs2 = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        iv = 1'b0; fl = 1'b0; ordy = 1'b1;
        repeat (3) tick();
        chk("squashed_200_seen", {63'd0, seen_200}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
